// File: rtl/dmem_arb_if.sv
// dmem_arb_if: bundles the MEM-stage, secondary and memory-side signals of dmem_arbiter.
// The arbiter takes the slave modport; requesters and memory model take the master modport.
interface dmem_arb_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();
   logic              p_req;
   logic              p_we;
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_wdata;
   logic [DATA_W-1:0] p_rdata;
   logic              p_done;
   logic              stall;

   logic              s_req;
   logic              s_we;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic [DATA_W-1:0] s_rdata;
   logic              s_done;

   logic              m_en;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;

   modport slave (
      input  p_req, p_we, p_addr, p_wdata,
      output p_rdata, p_done, stall,
      input  s_req, s_we, s_addr, s_wdata,
      output s_rdata, s_done,
      output m_en, m_we, m_addr, m_wdata,
      input  m_rdata
   );

   modport master (
      output p_req, p_we, p_addr, p_wdata,
      input  p_rdata, p_done, stall,
      output s_req, s_we, s_addr, s_wdata,
      input  s_rdata, s_done,
      input  m_en, m_we, m_addr, m_wdata,
      output m_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the MEM stage and a secondary requester.
// Define DMEM_ARB_PERF_CNT_EN to add the stall_cycles saturating stall counter output.
module dmem_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   dmem_arb_if.slave   bus_io
`ifdef DMEM_ARB_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StAccP = 2'd1;
   localparam logic [1:0] StAccS = 2'd2;

   localparam logic [3:0] LastCnt   = 4'(MEM_LAT - 1);
   localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [7:0]        starve_q, starve_d;
   logic              m_en_q, m_en_d;
   logic              m_we_q, m_we_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic              p_done_q, p_done_d;
   logic              s_done_q, s_done_d;
   logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
   logic [DATA_W-1:0] s_rdata_q, s_rdata_d;

   logic p_elig, s_elig, p_win, s_win;

   // A request whose done pulse is showing this cycle is finished and must not be re-granted.
   assign p_elig = bus_io.p_req & ~p_done_q;
   assign s_elig = bus_io.s_req & ~s_done_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      starve_d  = starve_q;
      m_en_d    = 1'b0;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      p_done_d  = 1'b0;
      s_done_d  = 1'b0;
      p_rdata_d = p_rdata_q;
      s_rdata_d = s_rdata_q;
      s_win     = 1'b0;
      p_win     = 1'b0;

      unique case (state_q)
         StIdle: begin
            // The raw p_req still blocks S, even in the cycle P is masked by its own done.
            s_win = s_elig & (~bus_io.p_req | (starve_q == StarveMax));
            p_win = p_elig & ~s_win;
            if (s_win) begin
               state_d   = StAccS;
               m_en_d    = 1'b1;
               m_we_d    = bus_io.s_we;
               m_addr_d  = bus_io.s_addr;
               m_wdata_d = bus_io.s_wdata;
               cnt_d     = '0;
            end else if (p_win) begin
               state_d   = StAccP;
               m_en_d    = 1'b1;
               m_we_d    = bus_io.p_we;
               m_addr_d  = bus_io.p_addr;
               m_wdata_d = bus_io.p_wdata;
               cnt_d     = '0;
            end
         end
         StAccP, StAccS: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LastCnt) begin
               state_d = StIdle;
               if (state_q == StAccP) begin
                  p_done_d  = 1'b1;
                  p_rdata_d = bus_io.m_rdata;
               end else begin
                  s_done_d  = 1'b1;
                  s_rdata_d = bus_io.m_rdata;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (s_win || !bus_io.s_req) begin
         starve_d = '0;
      end else if (p_win && s_elig && (starve_q != StarveMax)) begin
         starve_d = starve_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         starve_q  <= '0;
         m_en_q    <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         p_done_q  <= 1'b0;
         s_done_q  <= 1'b0;
         p_rdata_q <= '0;
         s_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         starve_q  <= starve_d;
         m_en_q    <= m_en_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         p_done_q  <= p_done_d;
         s_done_q  <= s_done_d;
         p_rdata_q <= p_rdata_d;
         s_rdata_q <= s_rdata_d;
      end
   end

   assign bus_io.stall   = bus_io.p_req & ~p_done_q;
   assign bus_io.p_done  = p_done_q;
   assign bus_io.p_rdata = p_rdata_q;
   assign bus_io.s_done  = s_done_q;
   assign bus_io.s_rdata = s_rdata_q;
   assign bus_io.m_en    = m_en_q;
   assign bus_io.m_we    = m_we_q;
   assign bus_io.m_addr  = m_addr_q;
   assign bus_io.m_wdata = m_wdata_q;

`ifdef DMEM_ARB_PERF_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (bus_io.stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
`endif

endmodule
